// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and lane helpers for the load/store unit
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } lsu_state_t;

   // Halfword marks use the aligned lane so an unchecked misaligned half never straddles the word.
   function automatic logic [3:0] lane_mark(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_B:    return 4'b0001 << lane;
         SZ_H:    return 4'b0011 << {lane[1], 1'b0};
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_B:    return {4{wdata[7:0]}};
         SZ_H:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic req_err(input logic [1:0] size, input logic [1:0] lane, input logic chk);
      logic misaligned;
      misaligned = ((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'b00));
      return (size == 2'd3) || (chk && misaligned);
   endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// rtl/lsu_mem_access_if.sv - CPU request/response and data-memory port bundle
interface lsu_mem_access_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              resp_err;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_writeEn;
   logic              mem_readEn;
   logic [3:0]        mem_mark;
   logic [DATA_W-1:0] mem_writeData;
   logic [DATA_W-1:0] mem_readData;

   // master: the surrounding CPU and memory; slave: the load/store unit
   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      output resp_ready, mem_readData,
      input  req_ready, resp_valid, resp_data, resp_err,
      input  mem_addr, mem_writeEn, mem_readEn, mem_mark, mem_writeData
   );

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      input  resp_ready, mem_readData,
      output req_ready, resp_valid, resp_data, resp_err,
      output mem_addr, mem_writeEn, mem_readEn, mem_mark, mem_writeData
   );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed load lane and sign/zero extends it
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  lane,
   output logic [31:0] data
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[{lane, 3'b000} +: 8];
      half_v = rdata[{lane[1], 4'b0000} +: 16];
      case (size)
         SZ_B:    data = uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
         SZ_H:    data = uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
         default: data = rdata;
      endcase
   end
endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - single-outstanding load/store unit in front of the data-memory port
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MISALIGN_CHK = 1
) (
   input logic            clk,
   input logic            rst_n,
   lsu_mem_access_if.slave bus
);
   lsu_state_t        state;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [1:0]        lane_q;

   logic              req_ready_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] resp_data_q;

   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_we_q;
   logic              mem_re_q;
   logic [3:0]        mem_mark_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic [31:0]       load_val;
   logic              accept_err;

   lsu_load_align u_align (
      .rdata (bus.mem_readData),
      .size  (size_q),
      .uns   (uns_q),
      .lane  (lane_q),
      .data  (load_val)
   );

   assign accept_err = req_err(bus.req_size, bus.req_addr[1:0], MISALIGN_CHK != 0);

   assign bus.req_ready     = req_ready_q;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_err      = resp_err_q;
   assign bus.resp_data     = resp_data_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_writeEn   = mem_we_q;
   assign bus.mem_readEn    = mem_re_q;
   assign bus.mem_mark      = mem_mark_q;
   assign bus.mem_writeData = mem_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         lane_q       <= 2'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_mark_q   <= 4'd0;
         mem_wdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  size_q      <= bus.req_size;
                  uns_q       <= bus.req_unsigned;
                  lane_q      <= bus.req_addr[1:0];
                  req_ready_q <= 1'b0;
                  if (accept_err) begin
                     // Erroneous requests skip the memory entirely.
                     state        <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_data_q  <= '0;
                  end else begin
                     state       <= ISSUE;
                     mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                     mem_we_q    <= bus.req_store;
                     mem_re_q    <= ~bus.req_store;
                     mem_mark_q  <= lane_mark(bus.req_size, bus.req_addr[1:0]);
                     mem_wdata_q <= store_lanes(bus.req_size, bus.req_wdata);
                  end
               end
            end
            ISSUE: begin
               mem_addr_q  <= '0;
               mem_we_q    <= 1'b0;
               mem_re_q    <= 1'b0;
               mem_mark_q  <= 4'd0;
               mem_wdata_q <= '0;
               if (mem_we_q) begin
                  state        <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_data_q  <= '0;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               // Read data is valid in the cycle after the read strobe.
               state        <= RESP;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_data_q  <= load_val;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state        <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  resp_data_q  <= '0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - randomized self-checking bench with a byte-addressed reference memory
module tb_lsu_mem_access;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   lsu_mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   lsu_mem_access #(.ADDR_W(32), .DATA_W(32), .MISALIGN_CHK(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference memory: 512 bytes at 0x80000000, addressed per byte.
   logic [7:0]  ref_b [0:511];
   // Device model storage, word organised, updated only from DUT strobes.
   logic [31:0] dev_w [0:127];
   bit          dev_init = 0;
   bit          hold_rd = 0;
   int          strobe_cnt = 0;
   int          both_cnt = 0;
   logic [31:0] s_addr;
   logic [3:0]  s_mark;
   logic [31:0] s_wd;
   logic        s_we;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!dev_init) begin
         for (int w = 0; w < 128; w++)
            dev_w[w] = {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
         dev_init = 1;
      end
      if (bus.mem_writeEn && bus.mem_readEn) both_cnt++;
      if (bus.mem_writeEn || bus.mem_readEn) begin
         strobe_cnt++;
         s_addr = bus.mem_addr;
         s_mark = bus.mem_mark;
         s_wd   = bus.mem_writeData;
         s_we   = bus.mem_writeEn;
      end
      if (bus.mem_writeEn)
         for (int i = 0; i < 4; i++)
            if (bus.mem_mark[i]) dev_w[bus.mem_addr[8:2]][8*i +: 8] = bus.mem_writeData[8*i +: 8];
      if (bus.mem_readEn) begin
         bus.mem_readData = dev_w[bus.mem_addr[8:2]];
         hold_rd = 1;
      end else if (hold_rd) begin
         hold_rd = 0;
      end else begin
         bus.mem_readData = $urandom;
      end
   end

   // Caller must be positioned just after a negedge; returns just after a negedge.
   task automatic do_req(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] ad,
                         input logic [31:0] wd, input int hold, input bit keep);
      logic [31:0] exp_d, exp_wd, raw;
      logic [63:0] mask;
      logic [3:0]  exp_mk;
      bit          err;
      int          off, nb, lat, n, base, exp_lat;
      off = int'(ad[8:0]);
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      err = (sz == 2'd3) || ((sz == 2'd1) && ad[0]) || ((sz == 2'd2) && (ad[1:0] != 2'b00));
      exp_mk = 4'd0;
      for (int i = 0; i < nb; i++) exp_mk[int'(ad[1:0]) + i] = 1'b1;
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
      exp_d = 32'd0;
      if (!err && !st) begin
         raw = 32'd0;
         for (int i = 0; i < nb; i++) raw = raw | (32'(ref_b[off+i]) << (8*i));
         mask = (64'd1 << (8*nb)) - 64'd1;
         exp_d = (!un && raw[8*nb-1]) ? (raw | ~mask[31:0]) : raw;
      end
      if (!err && st)
         for (int i = 0; i < nb; i++) ref_b[off+i] = wd[8*i +: 8];
      exp_lat = err ? 1 : (st ? 2 : 3);

      bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
      bus.req_unsigned = un; bus.req_addr = ad; bus.req_wdata = wd;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("req_wait", 64'(n), 64'd0);
      @(posedge clk);
      #1;
      if (!keep) bus.req_valid = 1'b0;
      base = strobe_cnt;
      lat = 1;
      @(negedge clk);
      while (!bus.resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", 64'(lat), 64'(exp_lat));
      check_eq("resp_data", 64'(bus.resp_data), 64'(exp_d));
      check_eq("resp_err", 64'(bus.resp_err), 64'(err));
      for (int h = 0; h < hold; h++) begin
         check_eq("busy_ready", 64'(bus.req_ready), 64'd0);
         @(negedge clk);
         check_eq("hold_valid", 64'(bus.resp_valid), 64'd1);
         check_eq("hold_data", 64'(bus.resp_data), 64'(exp_d));
      end
      check_eq("resp_ready_low", 64'(bus.req_ready), 64'd0);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      check_eq("resp_drop", 64'(bus.resp_valid), 64'd0);
      check_eq("strobes", 64'(strobe_cnt - base), err ? 64'd0 : 64'd1);
      if (!err) begin
         check_eq("mem_addr", 64'(s_addr), 64'(ad & 32'hFFFF_FFFC));
         check_eq("mem_mark", 64'(s_mark), 64'(exp_mk));
         check_eq("mem_dir", 64'(s_we), 64'(st));
         if (st) check_eq("mem_wdata", 64'(s_wd), 64'(exp_wd));
      end
   endtask

   initial begin
      int base;
      logic [31:0] v;
      for (int w = 0; w < 128; w++) begin
         v = $urandom;
         for (int i = 0; i < 4; i++) ref_b[4*w+i] = v[8*i +: 8];
      end
      v = 32'h12F4_5678;
      for (int i = 0; i < 4; i++) ref_b[i] = v[8*i +: 8];

      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      bus.resp_ready = 1'b0; bus.mem_readData = 32'd0;

      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check_eq("rst_resp_data", 64'(bus.resp_data), 64'd0);
      check_eq("rst_resp_err", 64'(bus.resp_err), 64'd0);
      check_eq("rst_mem", 64'({bus.mem_writeEn, bus.mem_readEn, bus.mem_mark, bus.mem_addr, bus.mem_writeData}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b0, 2'd0, 1'b0, 32'h8000_0002, 32'd0, 0, 1'b0);
      do_req(1'b0, 2'd0, 1'b1, 32'h8000_0002, 32'd0, 0, 1'b0);
      do_req(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'd0, 0, 1'b0);
      do_req(1'b0, 2'd1, 1'b0, 32'h8000_0000, 32'd0, 0, 1'b0);
      do_req(1'b1, 2'd2, 1'b0, 32'h8000_0104, 32'hDEAD_BEEF, 0, 1'b0);
      do_req(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00A5, 0, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0104, 32'd0, 0, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'd0, 0, 1'b0);
      do_req(1'b0, 2'd3, 1'b0, 32'h8000_0010, 32'd0, 1, 1'b0);

      // Stalled response with a competing request held valid throughout.
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'd0, 5, 1'b1);
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'd0, 0, 1'b0);

      // Reset during CAPTURE.
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'd2;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h8000_0000;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      base = strobe_cnt;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
      check_eq("abort_req_ready", 64'(bus.req_ready), 64'd1);
      check_eq("abort_strobes", 64'({bus.mem_writeEn, bus.mem_readEn, bus.mem_mark}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("abort_no_resp", 64'(bus.resp_valid), 64'd0);
      end
      check_eq("abort_strobe_cnt", 64'(strobe_cnt - base), 64'd1);

      for (int t = 0; t < 200; t++) begin
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'h8000_0000 | 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2), 1'b0);
      end

      check_eq("never_both_strobes", 64'(both_cnt), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
Load/store unit between the CPU execute stage and the data-memory port (writeEn/readEn/mark/addr/writeData/readData, read data valid the cycle after a sampled readEn).
- Accepts one memory request per valid/ready handshake and issues a single word-aligned access with a byte-lane mark.
- For loads, extracts and sign- or zero-extends the addressed lane, then returns a response over valid/ready.
- At most one request is outstanding at any time.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; only 32 is supported (4 byte lanes).
MISALIGN_CHK, 1, when 1 misaligned halfword/word requests return an error; when 0 low address bits are ignored.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  request valid.
req_ready  out  1  unit can accept a request.
req_store  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as an error.
req_unsigned  in  1  load zero-extends when set.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-justified.
resp_valid  out  1  response valid.
resp_ready  in  1  consumer accepts the response.
resp_data  out  DATA_W  extended load data; 0 for stores.
resp_err  out  1  misaligned or illegal-size request.
mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2], 2'b00}.
mem_writeEn  out  1  write strobe.
mem_readEn  out  1  read strobe.
mem_mark  out  4  byte-lane mask.
mem_writeData  out  DATA_W  lane-replicated store data.
mem_readData  in  DATA_W  word read data, valid the cycle after mem_readEn.

Behaviour:
- Reset (reset low, asynchronous), all values below hold until reset is released:
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, resp_err = 0.
  - All mem_* outputs = 0; request registers cleared.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch store, size, unsigned, addr and wdata.
  - If the request is erroneous: go to RESP with resp_err = 1 and make no memory access. Erroneous means size == 3, or MISALIGN_CHK with half and addr[0] != 0, or word and addr[1:0] != 0.
  - Otherwise go to ISSUE.
- ISSUE (exactly one cycle, outputs driven from registers):
  - mem_addr = word address; mark = 0001 << addr[1:0] (byte), 0011 << addr[1:0] (half), 1111 (word).
  - Store: mem_writeEn = 1, mem_writeData = {4{b}} for byte, {2{h}} for half, w for word. Go to RESP with resp_data = 0.
  - Load: mem_readEn = 1, go to CAPTURE.
- CAPTURE:
  - Select the lane of mem_readData by addr[1:0]: byte = [8*a+7 : 8*a]; half = [16*a[1]+15 : 16*a[1]].
  - Sign-extend unless req_unsigned, latch into resp_data, go to RESP.
- RESP:
  - resp_valid = 1; resp_data and resp_err are held stable while resp_ready = 0.
  - On resp_ready go to IDLE; resp_valid falls on the next edge.
- req_ready is 0 in every state except IDLE. There is no bypass, so a new request cannot be accepted in the same cycle a response is taken.
- mem_writeEn, mem_readEn and mem_mark are 0 in every state except ISSUE. They are never both 1.
- Latency, counted from the accept edge to the first resp_valid cycle:
  - Load: 3 cycles (ISSUE, CAPTURE, RESP).
  - Store: 2 cycles.
  - Error: 1 cycle.
- Reset asserted mid-operation aborts immediately with no further memory strobes. A write already issued stays committed.
- resp_err responses always carry resp_data = 0.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2.
  - state enum {IDLE, ISSUE, CAPTURE, RESP}.
  - function lane_mark(size, addr[1:0]).
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension, instantiated in CAPTURE.

Test Plan:
- sw addr 0x80000104 data 0xDEADBEEF -> one ISSUE cycle with mem_addr 0x80000104, mark 1111, writeData 0xDEADBEEF; resp_valid 2 cycles after accept, resp_data 0.
- sb addr 0x80000003 data 0x000000A5 -> mark 1000, writeData 0xA5A5A5A5, mem_addr 0x80000000.
- lb addr 0x80000002, memory word 0x12F45678 -> resp_data 0xFFFFFFF4; lbu on the same word -> 0x000000F4; lhu addr 0x80000002 -> 0x000012F4; lh addr 0x80000000 -> 0x00005678. resp_valid 3 cycles after accept.
- lw addr 0x80000001 with MISALIGN_CHK = 1 -> no mem strobes, resp_err = 1 on the cycle after accept, resp_data 0.
- resp_ready held 0 for 5 cycles during a load response -> resp_valid and resp_data stable, req_ready 0 throughout; a req_valid issued meanwhile is accepted only after the response handshake completes.
- reset asserted low during CAPTURE -> on that same edge/asynchronously resp_valid = 0, req_ready = 1, mem strobes 0; no response is produced after reset releases.
